// File: rtl/bcd_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_seg_scan
//  Purpose  : Captures a 3-digit BCD value (hundreds bit, tens, units) on a
//             load strobe and time-multiplexes it onto one 7-segment bus with
//             one-hot digit enables. Supports leading-zero blanking and flags
//             non-BCD digits.
//  Ports    : clk      - system clock, rising edge
//             rst_n    - asynchronous active-low reset
//             load     - capture strobe for h/t/u
//             h, t, u  - hundreds bit, tens BCD digit, units BCD digit
//             blank_lz - live leading-zero blanking enable
//             seg      - registered segments {g,f,e,d,c,b,a}
//             an       - registered one-hot digit enable (001 u, 010 t, 100 h)
//             bcd_err  - registered flag, high while a captured digit is > 9
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_seg_scan #(
  parameter int unsigned SCAN_DIV       = 4,    // cycles per digit, 1..65535
  parameter bit          SEG_ACTIVE_LOW = 1'b0  // 1 = invert seg for common anode
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       h,
  input  logic [3:0] t,
  input  logic [3:0] u,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       bcd_err
);

  localparam logic [15:0] C_CNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [1:0]  C_IDX_U    = 2'd0;
  localparam logic [1:0]  C_IDX_T    = 2'd1;
  localparam logic [1:0]  C_IDX_H    = 2'd2;
  // Reset value equals the decode of a units zero with the output polarity applied.
  localparam logic [6:0]  C_SEG_RST  = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;

  // Shadow registers, scan state and output registers
  logic        h_s_q, h_s_d;
  logic [3:0]  t_s_q, t_s_d;
  logic [3:0]  u_s_q, u_s_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  an_q,  an_d;
  logic [6:0]  seg_q, seg_d;
  logic        bcd_err_q, bcd_err_d;

  logic [3:0]  digit_sel;
  logic        blank_sel;
  logic [6:0]  seg_raw;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;  // non-BCD digit shows a dash
    endcase
    return s;
  endfunction

  always_comb begin
    // Capture
    h_s_d = h_s_q;
    t_s_d = t_s_q;
    u_s_d = u_s_q;
    if (load) begin
      h_s_d = h;
      t_s_d = t;
      u_s_d = u;
    end

    // Prescaler and scan index; with SCAN_DIV=1 the last count is 0, so the
    // index advances every cycle.
    cnt_d = cnt_q + 16'd1;
    idx_d = idx_q;
    if (cnt_q == C_CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q >= C_IDX_H) ? C_IDX_U : idx_q + 2'd1;
    end

    // Digit selection and blanking from pre-edge state
    digit_sel = u_s_q;
    blank_sel = 1'b0;
    an_d      = 3'b001;
    case (idx_q)
      C_IDX_T: begin
        digit_sel = t_s_q;
        // A tens zero is leading only when the hundreds is also zero; an
        // invalid tens digit is nonzero so it is never blanked.
        blank_sel = blank_lz && !h_s_q && (t_s_q == 4'd0);
        an_d      = 3'b010;
      end
      C_IDX_H: begin
        digit_sel = {3'b000, h_s_q};
        blank_sel = blank_lz && !h_s_q;
        an_d      = 3'b100;
      end
      default: begin
        digit_sel = u_s_q;
        blank_sel = 1'b0;
        an_d      = 3'b001;
      end
    endcase

    seg_raw   = blank_sel ? 7'h00 : seg_decode(digit_sel);
    // Polarity applies after blanking, so a blanked digit reads 7F when active-low.
    seg_d     = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;

    bcd_err_d = (t_s_q > 4'd9) || (u_s_q > 4'd9);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_s_q     <= 1'b0;
      t_s_q     <= 4'd0;
      u_s_q     <= 4'd0;
      cnt_q     <= '0;
      idx_q     <= C_IDX_U;
      an_q      <= 3'b001;
      seg_q     <= C_SEG_RST;
      bcd_err_q <= 1'b0;
    end else begin
      h_s_q     <= h_s_d;
      t_s_q     <= t_s_d;
      u_s_q     <= u_s_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      bcd_err_q <= bcd_err_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign bcd_err = bcd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_seg_scan
//  Purpose  : Self-checking bench for bcd_seg_scan. Two instances
//             (SCAN_DIV=4 active-high, SCAN_DIV=1 active-low) share stimulus;
//             a cycle-level reference model predicts every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_seg_scan;

  localparam int DIV_A = 4;
  localparam int DIV_B = 1;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic       h;
  logic [3:0] t;
  logic [3:0] u;
  logic       blank_lz;
  logic [6:0] seg_a, seg_b;
  logic [2:0] an_a, an_b;
  logic       err_a, err_b;

  int tests = 0;
  int fails = 0;

  bcd_seg_scan #(.SCAN_DIV(DIV_A), .SEG_ACTIVE_LOW(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .h(h), .t(t), .u(u),
    .blank_lz(blank_lz), .seg(seg_a), .an(an_a), .bcd_err(err_a)
  );

  bcd_seg_scan #(.SCAN_DIV(DIV_B), .SEG_ACTIVE_LOW(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .h(h), .t(t), .u(u),
    .blank_lz(blank_lz), .seg(seg_b), .an(an_b), .bcd_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  int         mk;       // clock edges since reset release
  logic       mh;
  logic [3:0] mt, mu;
  logic [2:0] exp_an_a, exp_an_b;
  logic [6:0] exp_seg_a, exp_seg_b;
  logic       exp_err;

  // Scan slot after k edges: each digit lasts div edges, three slots in turn.
  function automatic int slot_of(input int k, input int div);
    return (k / div) % 3;
  endfunction

  function automatic logic [6:0] model_seg(input int slot, input bit al, input logic sh,
                                           input logic [3:0] st, input logic [3:0] su,
                                           input logic bl_en);
    int         d;
    bit         bl;
    logic [6:0] r;
    d  = (slot == 0) ? int'(su) : (slot == 1) ? int'(st) : int'(sh);
    bl = bl_en && ((slot == 2 && sh == 1'b0) || (slot == 1 && sh == 1'b0 && st == 4'd0));
    r  = bl ? 7'h00 : lut[d];
    return al ? ~r : r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mk        <= 0;
      mh        <= 1'b0;
      mt        <= 4'd0;
      mu        <= 4'd0;
      exp_an_a  <= 3'b001;
      exp_an_b  <= 3'b001;
      exp_seg_a <= 7'h3F;
      exp_seg_b <= 7'h40;
      exp_err   <= 1'b0;
    end else begin
      exp_an_a  <= 3'(1 << slot_of(mk, DIV_A));
      exp_an_b  <= 3'(1 << slot_of(mk, DIV_B));
      exp_seg_a <= model_seg(slot_of(mk, DIV_A), 1'b0, mh, mt, mu, blank_lz);
      exp_seg_b <= model_seg(slot_of(mk, DIV_B), 1'b1, mh, mt, mu, blank_lz);
      exp_err   <= (mt > 4'd9) || (mu > 4'd9);
      if (load) begin
        mh <= h;
        mt <= t;
        mu <= u;
      end
      mk <= mk + 1;
    end
  end

  // ---------------------------------------------------------------- checks
  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_an_a",  7'(an_a),  7'(exp_an_a));
    check("model_seg_a", seg_a,     exp_seg_a);
    check("model_err_a", 7'(err_a), 7'(exp_err));
    check("model_an_b",  7'(an_b),  7'(exp_an_b));
    check("model_seg_b", seg_b,     exp_seg_b);
    check("model_err_b", 7'(err_b), 7'(exp_err));
  end

  // Waits (bounded) for the chosen instance's an to newly become tgt.
  task automatic wait_entry(input bit b, input logic [2:0] tgt, output bit hit);
    logic [2:0] prev, cur;
    prev = b ? an_b : an_a;
    hit  = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(negedge clk);
      cur = b ? an_b : an_a;
      if (cur == tgt && prev != tgt) hit = 1'b1;
      else prev = cur;
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL slot_timeout: an never became %b (got %b)", tgt, b ? an_b : an_a);
    end
  endtask

  task automatic slot(input bit b, input logic [2:0] tgt, input logic [6:0] exp_seg,
                      input string nm);
    bit hit;
    wait_entry(b, tgt, hit);
    if (hit) check(nm, b ? seg_b : seg_a, exp_seg);
  endtask

  // Called at a negedge; returns at the negedge after the shadows are in use.
  task automatic do_load(input logic lh, input logic [3:0] lt, input logic [3:0] lu);
    load = 1'b1; h = lh; t = lt; u = lu;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    bit hit;
    rst_n = 1'b1; load = 1'b0; h = 1'b0; t = 4'd0; u = 4'd0; blank_lz = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_an",    7'(an_a),  7'h01);
    check("rst_seg_a", seg_a,     7'h3F);
    check("rst_err",   7'(err_a), 7'h00);
    check("rst_seg_b", seg_b,     7'h40);

    // Release and watch the scan cadence
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("scan_hold_001", 7'(an_a), 7'h01);
    end
    @(negedge clk);
    check("scan_to_010", 7'(an_a), 7'h02);
    check("scan_seg_0",  seg_a,    7'h3F);

    // 75 without then with blanking
    do_load(1'b0, 4'd7, 4'd5);
    slot(1'b0, 3'b001, 7'h6D, "u75");
    slot(1'b0, 3'b010, 7'h07, "t75");
    slot(1'b0, 3'b100, 7'h3F, "h75");
    blank_lz = 1'b1;
    @(negedge clk);
    slot(1'b0, 3'b100, 7'h00, "h75_blank");
    slot(1'b0, 3'b001, 7'h6D, "u75_blank");
    slot(1'b0, 3'b010, 7'h07, "t75_blank");

    // 000 and 103 with blanking
    do_load(1'b0, 4'd0, 4'd0);
    slot(1'b0, 3'b001, 7'h3F, "u000");
    slot(1'b0, 3'b010, 7'h00, "t000");
    slot(1'b0, 3'b100, 7'h00, "h000");
    do_load(1'b1, 4'd0, 4'd3);
    slot(1'b0, 3'b001, 7'h4F, "u103");
    slot(1'b0, 3'b010, 7'h3F, "t103");
    slot(1'b0, 3'b100, 7'h06, "h103");

    // Non-BCD tens then recovery
    blank_lz = 1'b0;
    load = 1'b1; h = 1'b0; t = 4'hA; u = 4'd2;
    @(negedge clk);
    load = 1'b0;
    check("err_lat0", 7'(err_a), 7'h00);
    @(negedge clk);
    check("err_set",  7'(err_a), 7'h01);
    slot(1'b0, 3'b010, 7'h40, "t_dash");
    slot(1'b0, 3'b001, 7'h5B, "u_2");
    load = 1'b1; t = 4'd2; u = 4'd9;
    @(negedge clk);
    load = 1'b0;
    check("err_hold", 7'(err_a), 7'h01);
    @(negedge clk);
    check("err_clr",  7'(err_a), 7'h00);
    slot(1'b0, 3'b001, 7'h6F, "u_9");

    // Load coinciding with the scan advance edge
    do_load(1'b1, 4'd1, 4'd4);
    wait_entry(1'b0, 3'b001, hit);
    @(negedge clk);
    @(negedge clk);
    load = 1'b1; t = 4'd8;
    @(negedge clk);
    load = 1'b0;
    check("coin_pre_an", 7'(an_a), 7'h01);
    @(negedge clk);
    check("coin_an",  7'(an_a), 7'h02);
    check("coin_seg", seg_a,    7'h7F);

    // Asynchronous reset mid-digit
    #2 rst_n = 1'b0;
    #1;
    check("arst_an",    7'(an_a),  7'h01);
    check("arst_seg",   seg_a,     7'h3F);
    check("arst_err",   7'(err_a), 7'h00);
    check("arst_seg_b", seg_b,     7'h40);
    @(negedge clk);
    rst_n = 1'b1;

    // Active-low, SCAN_DIV=1 instance
    do_load(1'b1, 4'd2, 4'd3);
    slot(1'b1, 3'b001, 7'h30, "al_u");
    slot(1'b1, 3'b010, 7'h24, "al_t");
    slot(1'b1, 3'b100, 7'h79, "al_h");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 3) == 0);
      h    = 1'($urandom_range(0, 1));
      t    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      u    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 0 && t < 4'd3) t = 4'd0;
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Display stage directly downstream of the binary-to-BCD converter.
- Captures one hundreds bit plus tens and units BCD digits on a load strobe.
- Time-multiplexes the three digits onto one 7-segment bus with one-hot digit enables.
- Supports leading-zero blanking and flags non-BCD input digits.

Parameters:
- SCAN_DIV, 4, clock cycles each digit stays enabled before the scan advances; legal range 1..65535.
- SEG_ACTIVE_LOW, 0, 1 = `seg` output inverted for common-anode displays; `an` polarity is unaffected.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  capture strobe; h/t/u sampled on the rising edge where load=1.
- h  in  1  hundreds digit (0 or 1).
- t  in  4  tens BCD digit.
- u  in  4  units BCD digit.
- blank_lz  in  1  1 = blank leading zeros; sampled live, not captured.
- seg  out  7  segments {g,f,e,d,c,b,a}, registered.
- an  out  3  one-hot digit enable: 001 units, 010 tens, 100 hundreds; registered.
- bcd_err  out  1  high while a captured digit is >9; registered.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Shadow registers h_s=0, t_s=0, u_s=0.
  - Prescaler cnt=0, digit index idx=0 (units).
  - an=3'b001; seg=7'h3F ('0'; 7'h40 when SEG_ACTIVE_LOW=1); bcd_err=0.
- Release is synchronous to the next clk edge; no output glitch on deassertion.
- Capture:
  - On an edge with load=1, {h_s,t_s,u_s} <= {h,t,u}.
  - load=0 holds the shadows; continuous load=1 recaptures every cycle.
- Prescaler: cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - At the edge where cnt==SCAN_DIV-1, idx advances 0->1->2->0.
  - SCAN_DIV=1 advances idx every cycle.
- Output register: every edge, an <= onehot(idx) and seg <= decode(selected shadow digit, blanking), using pre-edge values.
  - Latency: one cycle from an idx or shadow change to an/seg.
  - Load and scan advance may coincide; both take effect, and the next edge shows the new digit at the new index.
- Decode (before polarity):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Digit 10..15 = 40 (dash).
  - The hundreds slot decodes {3'b0,h_s}.
- Blanking (seg=00 before polarity, an still asserted):
  - Hundreds is blanked when blank_lz=1 and h_s=0.
  - Tens is blanked when blank_lz=1, h_s=0 and t_s=0.
  - Units is never blanked.
  - An invalid tens digit is never blanked.
- Polarity: SEG_ACTIVE_LOW=1 inverts all seven seg bits after blanking, so a blanked digit outputs 7F.
- bcd_err: registered every edge as (t_s>9)|(u_s>9).
  - Clears one cycle after a valid capture.
  - Unaffected by scanning.
- Reset mid-scan immediately forces the reset values above; the scan restarts at units with cnt=0.

Test Plan:
- Reset, SCAN_DIV=4, SEG_ACTIVE_LOW=0, blank_lz=0, no load:
  - Immediately an=001, seg=3F, bcd_err=0.
  - After release, idx advances every 4 cycles, giving an sequence 001,010,100,001, each on the cycle after the advance edge.
  - seg stays 3F throughout.
- Load h=0,t=7,u=5 (binary 75), blank_lz=0:
  - Units slot seg=6D, tens slot 07, hundreds slot 3F.
  - Set blank_lz=1: hundreds slot seg=00 with an=100 still asserted; units and tens unchanged.
- Load h=0,t=0,u=0 with blank_lz=1:
  - Units slot 3F; tens and hundreds slots 00.
  - Load h=1,t=0,u=3: slots read 4F / 3F / 06, since the tens zero is no longer leading.
- Load t=4'hA,u=2:
  - bcd_err=1 one cycle after the load edge; tens slot seg=40, units 5B.
  - Then load t=2,u=9: bcd_err=0 one cycle later; units slot 6F.
- Assert load on the same edge as cnt==SCAN_DIV-1, t changing 1->8:
  - Next cycle an=010, seg=7F.
  - Assert rst_n=0 mid-digit: outputs return to an=001, seg=3F with no clock edge.
- SEG_ACTIVE_LOW=1, SCAN_DIV=1, load h=1,t=2,u=3, blank_lz=0:
  - an rotates every cycle.
  - seg cycles through units 30, tens 24, hundreds 79, i.e. the bitwise inverse of 4F, 5B, 06.
